// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared sizing helpers for the single-clock FIFO and its storage array.
//   fifo_depth()       : number of entries for a given address width
//   count_width()      : width of the occupancy counter (must hold 0..DEPTH)
//   thresholds_legal() : elaboration-time check of almost-full/almost-empty
// Optional feature macro used by the FIFO files: SYNC_FIFO_FWFT_EN
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Almost-full must be reachable and non-zero; almost-empty must leave the
    // full state distinguishable.
    function automatic bit thresholds_legal(input int addr_width,
                                            input int afull_thresh,
                                            input int aempty_thresh);
        int depth;
        depth = fifo_depth(addr_width);
        return (afull_thresh >= 1) && (afull_thresh <= depth) &&
               (aempty_thresh >= 0) && (aempty_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Simple dual-port storage for sync_fifo: one clocked write port, one read port.
// Read port is registered (1-cycle latency, output reset to 0, holds value when
// re is low) by default; with SYNC_FIFO_FWFT_EN defined it is a combinational
// look-up of raddr so the head word is always presented.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata : write port
//   re, raddr    : read enable / address
//   rdata        : read data
// -----------------------------------------------------------------------------
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    // Contents are deliberately not reset so the array maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr];

    // The read register does not exist in this mode.
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = rst ^ re;
`else
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and overflow/underflow error pulses.
// Default: registered read (rdata/rvalid one cycle after an accepted rinc).
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through (head word always shown,
// rvalid = !rempty, rinc pops it).
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   winc, wdata       : write request / data
//   wfull             : count == DEPTH
//   walmost_full      : count >= AFULL_THRESH
//   rinc              : read request (pop)
//   rdata, rvalid     : read data and its qualifier
//   rempty            : count == 0
//   ralmost_empty     : count <= AEMPTY_THRESH
//   count             : occupancy 0..DEPTH
//   overflow/underflow: one-cycle pulse after a rejected winc/rinc
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wfull,
    output logic                  walmost_full,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    if (!thresholds_legal(ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("sync_fifo: AFULL_THRESH/AEMPTY_THRESH out of range");
    end

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wfull_q, wfull_d;
    logic                  walmost_full_q, walmost_full_d;
    logic                  rempty_q, rempty_d;
    logic                  ralmost_empty_q, ralmost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wacc;
    logic                  racc;

    // Accept decisions use the registered flags, so a full FIFO with winc and
    // rinc together still rejects the write (and an empty one the read).
    assign wacc = winc && !wfull_q;
    assign racc = rinc && !rempty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wacc) begin
            wptr_d = wptr_q + 1'b1;   // wraps modulo DEPTH by width
        end
        if (racc) begin
            rptr_d = rptr_q + 1'b1;
        end

        count_d = count_q + CW'(wacc) - CW'(racc);

        // Flags come from the next count so they line up with count itself.
        wfull_d         = (count_d == DEPTH_C);
        walmost_full_d  = (count_d >= AFULL_C);
        rempty_d        = (count_d == '0);
        ralmost_empty_d = (count_d <= AEMPTY_C);

        overflow_d  = winc && wfull_q;
        underflow_d = rinc && rempty_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            wfull_q         <= 1'b0;
            walmost_full_q  <= 1'b0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            wfull_q         <= wfull_d;
            walmost_full_q  <= walmost_full_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

    // Storage. A read of the slot written on the previous edge sees the new
    // data; a same-edge read and write of one slot needs count 0 or DEPTH,
    // where one of the two is always rejected.
    sync_fifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wacc),
        .waddr (wptr_q),
        .wdata (wdata),
        .re    (racc),
        .raddr (rptr_q),
        .rdata (rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rvalid = !rempty_q;
`else
    logic rvalid_q, rvalid_d;

    always_comb begin
        rvalid_d = racc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
`endif

    assign wfull         = wfull_q;
    assign walmost_full  = walmost_full_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Directed bench for sync_fifo (default parameters). A queue holds the words
// the FIFO should contain; every clock step compares count, flags, error
// pulses and read data/valid against that queue.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        winc = 1'b0;
    logic        rinc = 1'b0;
    logic [31:0] wdata = '0;
    logic        wfull, walmost_full, rdata_unused_n;
    logic [31:0] rdata;
    logic        rvalid, rempty, ralmost_empty, overflow, underflow;
    logic [4:0]  count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] last_rdata = '0;

    assign rdata_unused_n = 1'b0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .winc          (winc),
        .wdata         (wdata),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rinc          (rinc),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive, update the reference queue, clock, compare.
    task automatic cycle(input logic w, input logic [31:0] d, input logic r);
        logic        ov, un, wa, ra;
        logic [31:0] exp;
        winc  = w;
        wdata = d;
        rinc  = r;
        ov  = w && (sb.size() == 16);
        un  = r && (sb.size() == 0);
        wa  = w && !ov;
        ra  = r && !un;
        exp = last_rdata;
        if (ra) exp = sb.pop_front();
        if (wa) sb.push_back(d);
        @(posedge clk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
        chk("count", 32'(count), 32'(sb.size()));
        chk("wfull", 32'(wfull), 32'(sb.size() == 16));
        chk("walmost_full", 32'(walmost_full), 32'(sb.size() >= 12));
        chk("rempty", 32'(rempty), 32'(sb.size() == 0));
        chk("ralmost_empty", 32'(ralmost_empty), 32'(sb.size() <= 4));
        chk("overflow", 32'(overflow), 32'(ov));
        chk("underflow", 32'(underflow), 32'(un));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rvalid", 32'(rvalid), 32'(sb.size() != 0));
        if (sb.size() != 0) chk("rdata_head", rdata, sb[0]);
`else
        chk("rvalid", 32'(rvalid), 32'(ra));
        chk("rdata", rdata, exp);
        last_rdata = exp;
`endif
        $display("txn t=%0t winc=%0b wdata=%0h rinc=%0b count=%0d rvalid=%0b rdata=%0h ovf=%0b unf=%0b",
                 $time, w, d, r, count, rvalid, rdata, overflow, underflow);
    endtask

    initial begin
        // Reset state, sampled while reset is held.
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_ralmost_empty", 32'(ralmost_empty), 32'd1);
        chk("rst_wfull", 32'(wfull), 32'd0);
        chk("rst_walmost_full", 32'(walmost_full), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_rdata", rdata, 32'd0);
`endif
        rst = 1'b0;

        // Fill, then one write too many.
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0);
        cycle(1'b1, 32'h1FF, 1'b0);

        // Drain, then one read too many.
        for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 32'h200 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 32'h0, 1'b1);

        // Simultaneous winc/rinc at count 5, at full and at empty.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h310 + 32'(i), 1'b1);
        for (int i = 0; i < 11; i++) cycle(1'b1, 32'h320 + 32'(i), 1'b0);
        cycle(1'b1, 32'h3FF, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h77, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // Mid-stream reset at count 7 with a read just completed.
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h400 + 32'(i), 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_rempty", 32'(rempty), 32'd1);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_ralmost_empty", 32'(ralmost_empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("midrst_rdata", rdata, 32'd0);
`endif
        sb.delete();
        last_rdata = '0;
        #1;
        rst = 1'b0;
        cycle(1'b1, 32'h55, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);

        // Single word into an empty FIFO, then popped.
        cycle(1'b1, 32'h33, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
